// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage integer register file.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PEND_W_DEF = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/reg_pending_ctr.sv
// Per-register count of in-flight writes; saturates at both ends so a protocol
// slip can never wrap the count into a bogus hazard state.
module reg_pending_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         nonzero
);

  assign full    = &count;
  assign nonzero = |count;

  // Issue and retire in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && nonzero) begin
      count <= count - 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && !inc && !nonzero))
        else $error("reg_pending_ctr: retire with no outstanding write");
    end
  end

endmodule

// File: rtl/regfile_writeback_sink.sv
// Decode-stage register file: writeback write port, two bypassed read ports
// and a pending-write scoreboard that raises a RAW/full stall for decode.
module regfile_writeback_sink
  import regfile_pkg::*;
#(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter int                        PEND_W         = PEND_W_DEF,
  parameter logic [BUS_DATA_WIDTH-1:0] SP_RESET       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inRegWrite,
  input  logic [4:0]                inDestReg,
  input  logic [BUS_DATA_WIDTH-1:0] inWriteData,
  input  logic                      inIssueValid,
  input  logic [4:0]                inIssueDestReg,
  input  logic [4:0]                inReadReg1,
  input  logic [4:0]                inReadReg2,
  output logic [BUS_DATA_WIDTH-1:0] outReadData1,
  output logic [BUS_DATA_WIDTH-1:0] outReadData2,
  output logic                      outStall
);

  logic [BUS_DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [PEND_W-1:0]         pend [REG_COUNT];
  logic [REG_COUNT-1:1]      inc;
  logic [REG_COUNT-1:1]      dec;
  logic [REG_COUNT-1:0]      full;
  logic [REG_COUNT-1:0]      nonzero;
  logic                      issue_fire;
  logic                      retire1;
  logic                      retire2;
  logic                      busy1;
  logic                      busy2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == 2) ? SP_RESET : '0;
      end
    end else if (inRegWrite && inDestReg != '0) begin
      regs[inDestReg] <= inWriteData;
    end
  end

  // x0 is hardwired; a write in flight to the read address wins over the array.
  always_comb begin
    outReadData1 = regs[inReadReg1];
    outReadData2 = regs[inReadReg2];
    if (inRegWrite && inDestReg == inReadReg1) outReadData1 = inWriteData;
    if (inRegWrite && inDestReg == inReadReg2) outReadData2 = inWriteData;
    if (inReadReg1 == '0) outReadData1 = '0;
    if (inReadReg2 == '0) outReadData2 = '0;
  end

  // The last outstanding write retiring now is served by the bypass, not a stall.
  assign retire1 = inRegWrite && inDestReg == inReadReg1;
  assign retire2 = inRegWrite && inDestReg == inReadReg2;
  assign busy1   = inReadReg1 != '0 && nonzero[inReadReg1]
                   && !(retire1 && pend[inReadReg1] == PEND_W'(1));
  assign busy2   = inReadReg2 != '0 && nonzero[inReadReg2]
                   && !(retire2 && pend[inReadReg2] == PEND_W'(1));
  assign outStall   = busy1 || busy2 || full[inIssueDestReg];
  assign issue_fire = inIssueValid && !outStall && inIssueDestReg != '0;

  assign pend[0]    = '0;
  assign full[0]    = 1'b0;
  assign nonzero[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_pend
    assign inc[r] = issue_fire && inIssueDestReg == reg_addr_t'(r);
    assign dec[r] = inRegWrite && inDestReg == reg_addr_t'(r);

    reg_pending_ctr #(.W(PEND_W)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc[r]),
      .dec    (dec[r]),
      .count  (pend[r]),
      .full   (full[r]),
      .nonzero(nonzero[r])
    );
  end

endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Directed bench for regfile_writeback_sink: reset, x0, bypass, RAW stall,
// same-cycle issue/retire and scoreboard-full behaviour.
module tb_regfile_writeback_sink;

  localparam logic [63:0] SP = 64'h0000_0000_0001_0000;

  logic        clk;
  logic        reset;
  logic        inRegWrite;
  logic [4:0]  inDestReg;
  logic [63:0] inWriteData;
  logic        inIssueValid;
  logic [4:0]  inIssueDestReg;
  logic [4:0]  inReadReg1;
  logic [4:0]  inReadReg2;
  logic [63:0] outReadData1;
  logic [63:0] outReadData2;
  logic        outStall;

  int vecCount  = 0;
  int missCount = 0;

  regfile_writeback_sink #(
    .BUS_DATA_WIDTH(64),
    .PEND_W        (3),
    .SP_RESET      (SP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inRegWrite    (inRegWrite),
    .inDestReg     (inDestReg),
    .inWriteData   (inWriteData),
    .inIssueValid  (inIssueValid),
    .inIssueDestReg(inIssueDestReg),
    .inReadReg1    (inReadReg1),
    .inReadReg2    (inReadReg2),
    .outReadData1  (outReadData1),
    .outReadData2  (outReadData2),
    .outStall      (outStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rw, input logic [4:0] dest,
                               input logic [63:0] wdata, input logic iv,
                               input logic [4:0] idest, input logic [4:0] r1,
                               input logic [4:0] r2);
    @(negedge clk);
    inRegWrite     = rw;
    inDestReg      = dest;
    inWriteData    = wdata;
    inIssueValid   = iv;
    inIssueDestReg = idest;
    inReadReg1     = r1;
    inReadReg2     = r2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    assert (observed === expected)
      else begin
        missCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    reset = 1'b1;
    inRegWrite = 1'b0; inDestReg = '0; inWriteData = '0;
    inIssueValid = 1'b0; inIssueDestReg = '0; inReadReg1 = '0; inReadReg2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 2, 1);
    checkOutput("init_x2", outReadData1, SP);
    checkOutput("init_x1", outReadData2, 64'h0);
    checkOutput("init_stall", 64'(outStall), 64'h0);

    applyStimulus(0, 0, 0, 1, 10, 0, 0);
    checkOutput("issue_x10_stall", 64'(outStall), 64'h0);
    applyStimulus(1, 10, 64'hAAAA, 0, 0, 10, 0);
    checkOutput("retire_x10_bypass", outReadData1, 64'hAAAA);
    checkOutput("retire_x10_stall", 64'(outStall), 64'h0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    applyStimulus(1, 2, 64'h77, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 5, 10);
    checkOutput("pend5_stall", 64'(outStall), 64'h1);
    checkOutput("x10_array", outReadData2, 64'hAAAA);
    applyStimulus(0, 0, 0, 0, 0, 2, 2);
    checkOutput("x2_written", outReadData1, 64'h77);

    @(negedge clk);
    reset = 1'b1;
    inReadReg1 = 5'd2;
    inReadReg2 = 5'd10;
    #1;
    checkOutput("rst_x2", outReadData1, SP);
    checkOutput("rst_x10", outReadData2, 64'h0);
    checkOutput("rst_stall", 64'(outStall), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 5, 10);
    checkOutput("post_rst_pend5", 64'(outStall), 64'h0);
    checkOutput("post_rst_x5", outReadData1, 64'h0);
    checkOutput("post_rst_x10", outReadData2, 64'h0);

    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("issue_x0_stall", 64'(outStall), 64'h0);
    applyStimulus(1, 0, 64'hDEAD_BEEF, 0, 0, 0, 0);
    checkOutput("x0_write_same", outReadData1, 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_read_after", outReadData2, 64'h0);

    applyStimulus(0, 0, 0, 1, 7, 0, 0);
    applyStimulus(1, 7, 64'h1234, 0, 0, 7, 0);
    checkOutput("bypass_x7", outReadData1, 64'h1234);
    checkOutput("bypass_x7_stall", 64'(outStall), 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    checkOutput("array_x7", outReadData1, 64'h1234);

    applyStimulus(0, 0, 0, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 3, 0);
    checkOutput("raw_x3_stall", 64'(outStall), 64'h1);
    applyStimulus(1, 3, 64'h55, 0, 0, 0, 3);
    checkOutput("raw_x3_retire_stall", 64'(outStall), 64'h0);
    checkOutput("raw_x3_retire_data", outReadData2, 64'h55);

    applyStimulus(0, 0, 0, 1, 4, 0, 0);
    applyStimulus(1, 4, 64'h44, 1, 4, 0, 0);
    checkOutput("iss_ret_x4_stall", 64'(outStall), 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    checkOutput("iss_ret_x4_pending", 64'(outStall), 64'h1);
    checkOutput("iss_ret_x4_data", outReadData1, 64'h44);
    applyStimulus(1, 4, 64'h99, 0, 0, 4, 0);
    checkOutput("x4_final_retire", 64'(outStall), 64'h0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 1, 9, 0, 0);
      checkOutput($sformatf("fill_x9_%0d", i), 64'(outStall), 64'h0);
    end
    applyStimulus(0, 0, 0, 1, 9, 0, 0);
    checkOutput("full_x9_stall", 64'(outStall), 64'h1);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1, 9, 64'(k), 0, 0, 9, 0);
      checkOutput($sformatf("drain_x9_%0d", k), 64'(outStall), (k < 7) ? 64'h1 : 64'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    checkOutput("drained_x9_stall", 64'(outStall), 64'h0);
    checkOutput("drained_x9_data", outReadData1, 64'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
